// File: rtl/mdio_peripheral.sv
// PHY-side Clause 22 MDIO slave: decodes controller frames, strobes a local
// register bank for writes, and serialises register data back for reads.
module mdio_peripheral #(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  output logic        reg_wr_en,
  output logic [15:0] reg_wr_data,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rd_data,
  output logic        busy,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    IDLE,
    ST1,
    HDR,
    TA_WR,
    WDATA,
    TA_RD,
    RDATA,
    SKIP
  } state_t;

  state_t      state_reg, state_next;
  logic        mdc_q;
  logic        rise, fall;
  logic [4:0]  count_reg, count_next;
  logic [14:0] shift_reg, shift_next;
  logic [15:0] tx_reg, tx_next;
  logic        ta_reg, ta_next;
  logic        latch_reg;
  logic        mdio_out_reg, mdio_out_next;
  logic        mdio_oe_reg, mdio_oe_next;
  logic [4:0]  reg_addr_reg, reg_addr_next;
  logic        reg_wr_en_reg, reg_wr_en_next;
  logic [15:0] reg_wr_data_reg, reg_wr_data_next;
  logic        reg_rd_en_reg, reg_rd_en_next;
  logic        frame_err_reg, frame_err_next;

  logic [11:0] hdr;
  logic [1:0]  op;
  logic [4:0]  phyad;
  logic [4:0]  regad;
  logic [15:0] wdata;

  assign rise  = mdc & ~mdc_q;
  assign fall  = ~mdc & mdc_q;

  // Header/data words as they stand including the bit sampled on this rise.
  assign hdr   = {shift_reg[10:0], mdio_in};
  assign op    = hdr[11:10];
  assign phyad = hdr[9:5];
  assign regad = hdr[4:0];
  assign wdata = {shift_reg, mdio_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      mdc_q           <= 1'b0;
      count_reg       <= 5'd0;
      shift_reg       <= 15'd0;
      tx_reg          <= 16'd0;
      ta_reg          <= 1'b0;
      latch_reg       <= 1'b0;
      mdio_out_reg    <= 1'b0;
      mdio_oe_reg     <= 1'b0;
      reg_addr_reg    <= 5'd0;
      reg_wr_en_reg   <= 1'b0;
      reg_wr_data_reg <= 16'd0;
      reg_rd_en_reg   <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      mdc_q           <= mdc;
      count_reg       <= count_next;
      shift_reg       <= shift_next;
      tx_reg          <= tx_next;
      ta_reg          <= ta_next;
      latch_reg       <= reg_rd_en_reg;
      mdio_out_reg    <= mdio_out_next;
      mdio_oe_reg     <= mdio_oe_next;
      reg_addr_reg    <= reg_addr_next;
      reg_wr_en_reg   <= reg_wr_en_next;
      reg_wr_data_reg <= reg_wr_data_next;
      reg_rd_en_reg   <= reg_rd_en_next;
      frame_err_reg   <= frame_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    count_next       = count_reg;
    shift_next       = shift_reg;
    tx_next          = tx_reg;
    ta_next          = ta_reg;
    mdio_out_next    = mdio_out_reg;
    mdio_oe_next     = mdio_oe_reg;
    reg_addr_next    = reg_addr_reg;
    reg_wr_data_next = reg_wr_data_reg;
    reg_wr_en_next   = 1'b0;
    reg_rd_en_next   = 1'b0;
    frame_err_next   = 1'b0;

    // Bank answers one clk after the strobe; capture it well before data bits.
    if (latch_reg) tx_next = reg_rd_data;

    case (state_reg)
      IDLE: begin
        if (rise && !mdio_in) state_next = ST1;
      end
      ST1: begin
        if (rise && mdio_in) begin
          state_next = HDR;
          count_next = 5'd12;
        end
      end
      HDR: begin
        if (rise) begin
          shift_next = {shift_reg[13:0], mdio_in};
          count_next = count_reg - 5'd1;
          if (count_reg == 5'd1) begin
            ta_next = 1'b0;
            if (phyad != PHY_ADDR || op == 2'b00 || op == 2'b11) begin
              frame_err_next = 1'b1;
              state_next     = SKIP;
              count_next     = 5'd18;
            end else if (op == 2'b01) begin
              reg_addr_next = regad;
              state_next    = TA_WR;
              count_next    = 5'd2;
            end else begin
              reg_addr_next  = regad;
              reg_rd_en_next = 1'b1;
              state_next     = TA_RD;
            end
          end
        end
      end
      TA_WR: begin
        if (rise) begin
          ta_next    = mdio_in;
          count_next = count_reg - 5'd1;
          if (count_reg == 5'd1) begin
            count_next = 5'd16;
            if ({ta_reg, mdio_in} == 2'b10) begin
              state_next = WDATA;
            end else begin
              frame_err_next = 1'b1;
              state_next     = SKIP;
            end
          end
        end
      end
      WDATA: begin
        if (rise) begin
          shift_next = {shift_reg[13:0], mdio_in};
          count_next = count_reg - 5'd1;
          if (count_reg == 5'd1) begin
            reg_wr_data_next = wdata;
            reg_wr_en_next   = 1'b1;
            state_next       = IDLE;
          end
        end
      end
      TA_RD: begin
        // First turnaround bit belongs to the controller; we drive the second as 0.
        if (fall) begin
          if (!ta_reg) begin
            ta_next = 1'b1;
          end else begin
            mdio_oe_next  = 1'b1;
            mdio_out_next = 1'b0;
            state_next    = RDATA;
            count_next    = 5'd16;
          end
        end
      end
      RDATA: begin
        if (fall) begin
          if (count_reg != 5'd0) begin
            mdio_oe_next  = 1'b1;
            mdio_out_next = tx_reg[15];
            tx_next       = {tx_reg[14:0], 1'b0};
            count_next    = count_reg - 5'd1;
          end else begin
            mdio_oe_next  = 1'b0;
            mdio_out_next = 1'b0;
            state_next    = IDLE;
          end
        end
      end
      SKIP: begin
        if (rise) begin
          count_next = count_reg - 5'd1;
          if (count_reg == 5'd1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mdio_out    = mdio_out_reg;
  assign mdio_oe     = mdio_oe_reg;
  assign reg_addr    = reg_addr_reg;
  assign reg_wr_en   = reg_wr_en_reg;
  assign reg_wr_data = reg_wr_data_reg;
  assign reg_rd_en   = reg_rd_en_reg;
  assign frame_err   = frame_err_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_mdio_peripheral.sv
// Bench for mdio_peripheral: drives Clause 22 frames as a controller would and
// compares strobes and read responses against a register-bank model.
module tb_mdio_peripheral;
  localparam logic [4:0] PHY = 5'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oe;
  logic [4:0]  reg_addr;
  logic        reg_wr_en;
  logic [15:0] reg_wr_data;
  logic        reg_rd_en;
  logic [15:0] reg_rd_data;
  logic        busy;
  logic        frame_err;

  mdio_peripheral #(.PHY_ADDR(PHY)) dut (
    .clk(clk), .reset(reset), .mdc(mdc), .mdio_in(mdio_in),
    .mdio_out(mdio_out), .mdio_oe(mdio_oe), .reg_addr(reg_addr),
    .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Register bank seen by the DUT (registered read) and the bench's own model of it.
  logic [15:0] bank [32];
  logic [15:0] model [32];
  logic        bk_we = 1'b0;
  logic [4:0]  bk_addr = 5'd0;
  logic [15:0] bk_data = 16'd0;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, oe_cyc = 0;
  logic [4:0]  wr_addr_s = 5'd0, rd_addr_s = 5'd0;
  logic [15:0] wr_data_s = 16'd0;

  always @(posedge clk) begin
    if (bk_we) bank[bk_addr] <= bk_data;
    if (reg_wr_en) begin
      wr_cnt++;
      wr_addr_s = reg_addr;
      wr_data_s = reg_wr_data;
      bank[reg_addr] <= reg_wr_data;
    end
    if (reg_rd_en) begin
      rd_cnt++;
      rd_addr_s = reg_addr;
      reg_rd_data <= bank[reg_addr];
    end
    if (frame_err) err_cnt++;
    if (mdio_oe) oe_cyc++;
  end

  // Results of the most recent frame
  int d_err, d_wr, d_rd, d_oe;
  logic [17:0] r_oe, r_out;
  logic fin_oe, fin_busy, mid_busy;
  logic [4:0] last_addr;

  task automatic set_reg(input logic [4:0] a, input logic [15:0] d);
    bk_addr = a; bk_data = d; bk_we = 1'b1;
    @(posedge clk); #1;
    bk_we = 1'b0;
    model[a] = d;
  endtask

  // One MDC period: low half (controller sets data), then rising edge.
  task automatic send_bit(input logic b, output logic oe_s, output logic out_s, output logic bz);
    mdio_in = b;
    mdc = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    oe_s = mdio_oe; out_s = mdio_out; bz = busy;
    mdc = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                           input logic [4:0] regad, input logic [1:0] ta, input logic [15:0] data);
    logic [31:0] f;
    logic o, d, bz;
    int e0, w0, r0, c0;
    e0 = err_cnt; w0 = wr_cnt; r0 = rd_cnt; c0 = oe_cyc;
    f = {2'b01, op, phy, regad, ta, data};
    for (int i = 0; i < pre; i++) send_bit(1'b1, o, d, bz);
    for (int i = 0; i < 14; i++) send_bit(f[31-i], o, d, bz);
    for (int i = 0; i < 18; i++) begin
      send_bit((op == 2'b10) ? 1'b1 : f[17-i], o, d, bz);
      r_oe[17-i] = o;
      r_out[17-i] = d;
      mid_busy = bz;
    end
    mdio_in = 1'b1;
    mdc = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    fin_oe = mdio_oe; fin_busy = busy;
    d_err = err_cnt - e0; d_wr = wr_cnt - w0; d_rd = rd_cnt - r0; d_oe = oe_cyc - c0;
  endtask

  task automatic test_reset();
    checks++;
    if ({mdio_oe, mdio_out, busy, reg_wr_en, reg_rd_en, frame_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 000000", {mdio_oe, mdio_out, busy, reg_wr_en, reg_rd_en, frame_err});
    end
    checks++;
    if ({reg_addr, reg_wr_data} !== 21'd0) begin
      failures++;
      $display("FAIL reset_data: got addr=%0d wdata=%h want 0/0000", reg_addr, reg_wr_data);
    end
  endtask

  task automatic test_write();
    logic [4:0] a;
    logic [15:0] d;
    for (int n = 0; n < 6; n++) begin
      a = (n == 0) ? 5'd3 : 5'($urandom_range(0, 31));
      d = (n == 0) ? 16'hA5C3 : 16'($urandom);
      run_frame(n % 3, 2'b01, PHY, a, 2'b10, d);
      model[a] = d;
      last_addr = a;
      $display("write reg=%0d data=%h wr=%0d addr=%0d wdata=%h", a, d, d_wr, wr_addr_s, wr_data_s);
      checks++;
      if (d_wr !== 1 || d_rd !== 0 || d_err !== 0) begin
        failures++;
        $display("FAIL write_strobes: got wr=%0d rd=%0d err=%0d want 1/0/0", d_wr, d_rd, d_err);
      end
      checks++;
      if (wr_addr_s !== a || wr_data_s !== d) begin
        failures++;
        $display("FAIL write_value: got addr=%0d data=%h want %0d/%h", wr_addr_s, wr_data_s, a, d);
      end
      checks++;
      if (d_oe !== 0 || fin_busy !== 1'b0) begin
        failures++;
        $display("FAIL write_bus: got oe_cycles=%0d busy=%b want 0/0", d_oe, fin_busy);
      end
    end
  endtask

  task automatic check_read_frame_inline_dummy(); endtask

  task automatic test_read();
    logic [4:0] a;
    set_reg(5'd7, 16'h1234);
    for (int n = 0; n < 7; n++) begin
      a = (n == 0) ? 5'd7 : 5'($urandom_range(0, 31));
      run_frame(0, 2'b10, PHY, a, 2'b00, 16'd0);
      last_addr = a;
      $display("read reg=%0d exp=%h oe=%b out=%b rd=%0d", a, model[a], r_oe, r_out, d_rd);
      checks++;
      if (d_rd !== 1 || rd_addr_s !== a || d_wr !== 0 || d_err !== 0) begin
        failures++;
        $display("FAIL read_strobe: got rd=%0d addr=%0d wr=%0d err=%0d want 1/%0d/0/0", d_rd, rd_addr_s, d_wr, d_err, a);
      end
      checks++;
      if (r_oe !== {1'b0, 17'h1FFFF}) begin
        failures++;
        $display("FAIL read_oe: got %b want %b", r_oe, {1'b0, 17'h1FFFF});
      end
      checks++;
      if (r_out !== {2'b00, model[a]}) begin
        failures++;
        $display("FAIL read_data: got %b want %b", r_out, {2'b00, model[a]});
      end
      checks++;
      if (fin_oe !== 1'b0 || fin_busy !== 1'b0 || d_oe !== 17 * 8) begin
        failures++;
        $display("FAIL read_release: got oe=%b busy=%b oe_cycles=%0d want 0/0/136", fin_oe, fin_busy, d_oe);
      end
    end
  endtask

  task automatic test_errors();
    logic [1:0] op, ta;
    logic [4:0] phy, a;
    int kind;
    for (int n = 0; n < 9; n++) begin
      kind = (n < 5) ? n : $urandom_range(0, 4);
      op = 2'b01; phy = PHY; ta = 2'b10;
      a = 5'($urandom_range(0, 31));
      case (kind)
        0: phy = (n == 0) ? 5'd2 : PHY ^ 5'($urandom_range(1, 31));
        1: op = 2'b11;
        2: ta = 2'b11;
        3: op = 2'b00;
        default: begin op = 2'b10; phy = PHY ^ 5'($urandom_range(1, 31)); end
      endcase
      if (kind == 2) ta = (n == 2) ? 2'b11 : (($urandom_range(0, 1) == 1) ? 2'b00 : 2'b01);
      if (phy == PHY && (op == 2'b01 || op == 2'b10)) last_addr = a;
      run_frame(0, op, phy, a, ta, 16'($urandom));
      $display("error kind=%0d op=%b phy=%0d ta=%b err=%0d wr=%0d rd=%0d", kind, op, phy, ta, d_err, d_wr, d_rd);
      checks++;
      if (d_err !== 1 || d_wr !== 0 || d_rd !== 0) begin
        failures++;
        $display("FAIL err_strobes: got err=%0d wr=%0d rd=%0d want 1/0/0", d_err, d_wr, d_rd);
      end
      checks++;
      if (d_oe !== 0 || mid_busy !== 1'b1 || fin_busy !== 1'b0) begin
        failures++;
        $display("FAIL err_skip: got oe_cycles=%0d busy_last=%b busy_end=%b want 0/1/0", d_oe, mid_busy, fin_busy);
      end
      checks++;
      if (reg_addr !== last_addr) begin
        failures++;
        $display("FAIL err_addr_hold: got %0d want %0d", reg_addr, last_addr);
      end
    end
    run_frame(0, 2'b01, PHY, 5'd5, 2'b10, 16'hFFFF);
    model[5] = 16'hFFFF;
    $display("write after errors reg=5 wr=%0d addr=%0d data=%h", d_wr, wr_addr_s, wr_data_s);
    checks++;
    if (d_wr !== 1 || wr_addr_s !== 5'd5 || wr_data_s !== 16'hFFFF || d_err !== 0) begin
      failures++;
      $display("FAIL recover_write: got wr=%0d addr=%0d data=%h err=%0d want 1/5/ffff/0", d_wr, wr_addr_s, wr_data_s, d_err);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] f;
    logic o, d, bz;
    logic [4:0] a;
    a = 5'($urandom_range(1, 31));
    set_reg(a, 16'($urandom) | 16'h0800);
    f = {2'b01, 2'b10, PHY, a, 18'h3FFFF};
    for (int i = 0; i < 21; i++) send_bit(f[31-i], o, d, bz);
    checks++;
    if (mdio_oe !== 1'b1 || mdio_out !== 1'b1) begin
      failures++;
      $display("FAIL mid_read_drive: got oe=%b out=%b want 1/1", mdio_oe, mdio_out);
    end
    #1 reset = 1'b1;
    #1;
    $display("reset mid-read reg=%0d oe=%b out=%b busy=%b", a, mdio_oe, mdio_out, busy);
    checks++;
    if (mdio_oe !== 1'b0 || mdio_out !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got oe=%b out=%b busy=%b want 0/0/0", mdio_oe, mdio_out, busy);
    end
    mdc = 1'b0;
    mdio_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    run_frame(0, 2'b10, PHY, 5'd0, 2'b00, 16'd0);
    $display("read after reset reg=0 exp=%h out=%b", model[0], r_out);
    checks++;
    if (d_rd !== 1 || r_oe !== {1'b0, 17'h1FFFF} || r_out !== {2'b00, model[0]} || fin_oe !== 1'b0) begin
      failures++;
      $display("FAIL read_after_reset: got rd=%0d oe=%b out=%b want 1/%b/%b", d_rd, r_oe, r_out, {1'b0, 17'h1FFFF}, {2'b00, model[0]});
    end
  endtask

  task automatic test_back_to_back();
    run_frame(32, 2'b01, PHY, 5'd31, 2'b10, 16'h0001);
    $display("preamble write reg=31 wr=%0d addr=%0d data=%h", d_wr, wr_addr_s, wr_data_s);
    checks++;
    if (d_wr !== 1 || wr_addr_s !== 5'd31 || wr_data_s !== 16'h0001) begin
      failures++;
      $display("FAIL preamble_write: got wr=%0d addr=%0d data=%h want 1/31/0001", d_wr, wr_addr_s, wr_data_s);
    end
    run_frame(0, 2'b01, PHY, 5'd31, 2'b10, 16'h8000);
    model[31] = 16'h8000;
    $display("back-to-back write reg=31 wr=%0d addr=%0d data=%h", d_wr, wr_addr_s, wr_data_s);
    checks++;
    if (d_wr !== 1 || wr_addr_s !== 5'd31 || wr_data_s !== 16'h8000) begin
      failures++;
      $display("FAIL b2b_write: got wr=%0d addr=%0d data=%h want 1/31/8000", d_wr, wr_addr_s, wr_data_s);
    end
    run_frame(0, 2'b10, PHY, 5'd31, 2'b00, 16'd0);
    $display("readback reg=31 out=%b", r_out);
    checks++;
    if (r_out !== {2'b00, model[31]}) begin
      failures++;
      $display("FAIL b2b_readback: got %b want %b", r_out, {2'b00, model[31]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    mdc = 1'b0;
    mdio_in = 1'b1;
    last_addr = 5'd0;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) set_reg(5'(i), 16'($urandom));
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_write();
    test_read();
    test_errors();
    test_reset_mid_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdio_peripheral.md
Name: mdio_peripheral

Overview:
- PHY-side MDIO management slave. It consumes the MDC/MDIO stream produced by the team's MDIO management controller.
- Decodes IEEE 802.3 Clause 22 frames: ST=01, OP, PHYAD[4:0], REGAD[4:0], TA, DATA[15:0], all MSB first.
- Writes are forwarded to a local register bank as a one-cycle write strobe.
- For reads, it fetches the register-bank word and drives it back on MDIO.
- Sits directly downstream of the controller on the management bus, in the same clk domain.

Parameters:
- PHY_ADDR, 5'd1, address this peripheral answers to; frames for other addresses are ignored.

Ports:
- clk  input  1  system clock; MDC is generated from it
- reset  input  1  asynchronous, active-high reset
- mdc  input  1  management clock; synchronous to clk, edge-detected (no synchronizer)
- mdio_in  input  1  serial data from controller
- mdio_out  output  1  serial data to controller during read data phase
- mdio_oe  output  1  1 = peripheral drives MDIO
- reg_addr  output  5  register address of current frame
- reg_wr_en  output  1  one-clk pulse: write reg_wr_data to reg_addr
- reg_wr_data  output  16  write data
- reg_rd_en  output  1  one-clk pulse: request read of reg_addr
- reg_rd_data  input  16  register contents; valid exactly 1 clk after reg_rd_en
- busy  output  1  1 while a frame is being decoded or answered (state != IDLE)
- frame_err  output  1  one-clk pulse on bad OP, bad write TA, or PHY address mismatch

Behaviour:
- Reset (async, active-high): state=IDLE; mdc_q=0; all outputs 0; shift register and bit counter cleared. Reset mid-frame aborts immediately and releases MDIO.
- Edges are detected in the clk domain from the registered previous mdc value (mdc_q):
  - rise = mdc & ~mdc_q
  - fall = ~mdc & mdc_q
- mdio_in is sampled only on rise; mdio_out/mdio_oe change only on fall.
- States and transitions:
  - IDLE: sampled 0 -> ST1; sampled 1 -> stay (preamble optional).
  - ST1: sampled 1 -> HDR, count=12; sampled 0 -> stay.
  - HDR: shift in OP(2), PHYAD(5), REGAD(5) over 12 rises. On the 12th rise:
    - PHYAD != PHY_ADDR or OP in {00,11} -> frame_err pulse, SKIP with count=18.
    - OP=01 -> TA_WR, count=2.
    - OP=10 -> assert reg_addr, pulse reg_rd_en, go TA_RD.
  - TA_WR: sample 2 bits; both must be 1,0. On mismatch -> frame_err, SKIP with count=16. Otherwise -> WDATA, count=16.
  - WDATA: 16 rises shift in data. On the 16th rise: reg_wr_data and reg_addr are valid and reg_wr_en pulses in the same clk; -> IDLE.
  - TA_RD:
    - Latch reg_rd_data into the tx shift register on the clk after reg_rd_en.
    - First fall: mdio_oe stays 0 (controller-released TA bit).
    - Second fall: mdio_oe=1, mdio_out=0.
    - Then -> RDATA, count=16.
  - RDATA: each fall drives the next data bit, MSB first. On the fall after bit 0 has been driven: mdio_oe=0, mdio_out=0, -> IDLE.
  - SKIP: count remaining rises without driving (mdio_oe=0); at 0 -> IDLE.
- reg_addr holds its last value until the next valid header.
- reg_wr_data holds until the next write.
- Simultaneous events:
  - A rise and a fall cannot occur in the same clk.
  - If reg_rd_data latching coincides with a fall, the latch takes effect before the first driven bit; the data is always fully captured before bit 15 is driven.
- mdio_oe is never 1 outside TA_RD (second bit) and RDATA.
- busy=0 only in IDLE.
- frame_err is exactly one clk wide.

Test Plan:
- Write, PHY_ADDR=1: frame 01 01 00001 00011 10 0xA5C3 -> single reg_wr_en pulse with reg_addr=3 and reg_wr_data=0xA5C3; mdio_oe stays 0 throughout; busy returns to 0.
- Read: reg bank returns 0x1234 for reg 7; frame 01 10 00001 00111 -> one reg_rd_en pulse with reg_addr=7. Required MDIO response:
  - mdio_oe=0 for TA bit 1;
  - TA bit 2 driven 0;
  - then bits 0001001000110100 on successive falls;
  - mdio_oe=0 after the last bit.
- Address mismatch: write frame to PHYAD=2 -> frame_err pulse; no reg_wr_en or reg_rd_en; mdio_oe=0; busy drops after the remaining 18 bits.
- Bad OP=11 and bad write TA=11 -> frame_err pulse each time, no register strobe. The next valid write to reg 5 with data 0xFFFF succeeds.
- Reset asserted mid-RDATA (after 5 data bits) -> mdio_oe, mdio_out and busy go 0 asynchronously. A following read frame for reg 0 is answered correctly.
- Preamble of 32 ones followed by a write to reg 31 with data 0x0001 -> accepted; back-to-back second write with data 0x8000 also accepted.
